// File: rtl/drm_rd_stream.sv
// Read-side sequencer for the drm_32x16384 block RAM: turns (addr, len) commands into
// a credit-limited read stream. Define DRM_RD_STREAM_OUTPUT_REG_EN for a RAM with OUTPUT_REG=1 (L=2).
module drm_rd_stream #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

`ifdef DRM_RD_STREAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = PW + 2;

  if (FIFO_DEPTH < LAT + 2) begin : g_depth_chk
    $error("drm_rd_stream: FIFO_DEPTH must be at least read latency + 2");
  end
  if ((1 << PW) != FIFO_DEPTH) begin : g_pow2_chk
    $error("drm_rd_stream: FIFO_DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]     beats_q, beats_d;
  logic [LAT-1:0]          tag_q, tag_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];

  logic                    fifo_valid;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           credit_used;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_mem_d  = fifo_mem_q;

    fifo_valid = (count_q != '0);
    pop        = fifo_valid && m_ready;
    push       = tag_q[LAT-1];

    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
    // The same-cycle pop frees a slot, so a draining full FIFO can still issue.
    credit_used = CW'(count_q) + inflight - CW'(pop);
    issue = (state_q == S_RUN) && (remaining_q != '0) && (credit_used < CW'(FIFO_DEPTH));

    tag_d    = tag_q << 1;
    tag_d[0] = issue;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = ram_rd_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          beats_d     = cmd_len;
          state_d     = (cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
        end
        if (pop) begin
          beats_d = beats_q - (ADDR_WIDTH + 1)'(1);
          if (beats_q == (ADDR_WIDTH + 1)'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_mem_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign cmd_ready   = !rd_rst && (state_q == S_IDLE);
  assign busy        = !rd_rst && (state_q == S_RUN);
  assign done        = !rd_rst && (state_q == S_DONE);
  assign ram_rd_en   = !rd_rst && issue;
  assign ram_rd_addr = rd_rst ? '0 : addr_q;
  assign m_valid     = !rd_rst && fifo_valid;
  assign m_last      = !rd_rst && fifo_valid && (beats_q == (ADDR_WIDTH + 1)'(1));
  assign m_data      = rd_rst ? '0 : fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_drm_rd_stream.sv
// Scoreboard bench for drm_rd_stream with a behavioural RAM preloaded as data = 0xFFFFFFFF - addr.
module tb_drm_rd_stream;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef DRM_RD_STREAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rd_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  drm_rd_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return 32'hFFFF_FFFF - {{(DW-AW){1'b0}}, a};
  endfunction

  // Behavioural RAM read port: one register stage, plus an output register when L=2.
  logic [DW-1:0] ram_s1 = '0;
  logic [DW-1:0] ram_s2 = '0;
  always @(posedge rd_clk) begin
    if (ram_rd_en) ram_s1 <= ram_word(ram_rd_addr);
    ram_s2 <= ram_s1;
  end
  assign ram_rd_data = (LAT == 2) ? ram_s2 : ram_s1;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int            cyc = 0;
  always @(posedge rd_clk) cyc <= cyc + 1;

  // Downstream ready: mode 0 holds ready high, mode 1 toggles then stalls for 10 cycles.
  int ready_mode = 0;
  int rcnt = 0;
  always @(posedge rd_clk) begin
    #1;
    if (ready_mode == 0) begin
      m_ready = 1'b1;
    end else begin
      if (rcnt < 20)      m_ready = rcnt[0];
      else if (rcnt < 30) m_ready = 1'b0;
      else                m_ready = 1'b1;
      rcnt++;
    end
  end

  exp_t          exp_q[$];
  logic [AW-1:0] exp_rd_addr = '0;
  int            issue_cnt = 0;
  int            hs_cnt = 0;
  int            out_cnt = 0;
  int            first_en = -1;
  int            first_valid = -1;
  int            done_cyc = -1;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Monitor: address sequence, credit bound, stall stability and scoreboard compare.
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      prev_valid = 1'b0;
    end else begin
      if (ram_rd_en) begin
        checkOutput("rd_addr", 64'(ram_rd_addr), 64'(exp_rd_addr));
        exp_rd_addr = exp_rd_addr + 14'd1;
        issue_cnt++;
        if (first_en < 0) first_en = cyc;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", 64'(m_valid), 64'd1);
        checkOutput("hold_data", 64'(m_data), 64'(prev_data));
        checkOutput("hold_last", 64'(m_last), 64'(prev_last));
      end
      out_cnt = out_cnt + int'(ram_rd_en) - int'(m_valid && m_ready);
      if (ram_rd_en) checkOutput("credit_bound", 64'(out_cnt <= DEPTH), 64'd1);
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("m_data", 64'(m_data), 64'(e.data));
          checkOutput("m_last", 64'(m_last), 64'(e.last));
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  int t_acc = 0;

  task automatic driveCommand(input logic [AW-1:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      logic [AW-1:0] a;
      a = addr + AW'(i);
      e.data = ram_word(a);
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    exp_rd_addr = addr;
    issue_cnt   = 0;
    hs_cnt      = 0;
    first_en    = -1;
    first_valid = -1;
    done_cyc    = -1;
    @(posedge rd_clk);
    #1;
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = (AW+1)'(len);
    t_acc     = cyc;
    @(posedge rd_clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'(len != 0));
    checkOutput("done_after_accept", 64'(done), 64'(len == 0));
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input int len, input bit timed);
    bit seen;
    driveCommand(addr, len);
    seen = 1'b0;
    for (int k = 0; k < len * 4 + 200; k++) begin
      @(posedge rd_clk);
      if (done_cyc >= 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
    end else begin
      #1;
      checkOutput("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    end
    checkOutput("issue_count", 64'(issue_cnt), 64'(len));
    checkOutput("beat_count", 64'(hs_cnt), 64'(len));
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    if (timed) begin
      if (len == 0) begin
        checkOutput("no_rd_en", 64'(first_en), 64'(-1));
        checkOutput("no_m_valid", 64'(first_valid), 64'(-1));
        checkOutput("done_cycle", 64'(done_cyc), 64'(t_acc + 1));
      end else begin
        checkOutput("first_rd_en", 64'(first_en), 64'(t_acc + 1));
        checkOutput("first_m_valid", 64'(first_valid), 64'(t_acc + 2 + LAT));
        checkOutput("done_cycle", 64'(done_cyc), 64'(t_acc + len + LAT + 2));
      end
    end
  endtask

  initial begin
    $display("[TB] start, read latency %0d", LAT);
    rd_rst = 1'b1;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_rd_en", 64'(ram_rd_en), 64'd0);
    checkOutput("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_busy_done", 64'({busy, done}), 64'd0);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    @(posedge rd_clk);
    #1;
    checkOutput("cmd_ready_post_rst", 64'(cmd_ready), 64'd1);

    $display("[TB] basic burst");
    applyStimulus(14'h0000, 16, 1'b1);

    $display("[TB] backpressure");
    rcnt = 0;
    ready_mode = 1;
    applyStimulus(14'h0200, 64, 1'b0);
    ready_mode = 0;

    $display("[TB] address wrap");
    applyStimulus(14'h3FFE, 4, 1'b1);

    $display("[TB] edge lengths");
    applyStimulus(14'h0123, 1, 1'b1);
    applyStimulus(14'h0050, 0, 1'b1);
    applyStimulus(14'h0000, 16384, 1'b1);

    $display("[TB] reset mid-burst");
    driveCommand(14'h0000, 32);
    for (int k = 0; k < 200 && hs_cnt < 5; k++) @(posedge rd_clk);
    checkOutput("reached_beat5", 64'(hs_cnt >= 5), 64'd1);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    checkOutput("midrst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_rd_en", 64'(ram_rd_en), 64'd0);
    @(posedge rd_clk);
    @(posedge rd_clk);
    #1;
    exp_q.delete();
    out_cnt = 0;
    rd_rst = 1'b0;
    applyStimulus(14'h0100, 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
